// File: rtl/sprite_cmd_pkg.sv
// Shared definitions for the sprite command scheduler: command word field
// layout, info codes, scheduler state encoding and small word helpers.
package sprite_cmd_pkg;

    localparam int SUB_COMP_MSB = 31;
    localparam int SUB_COMP_LSB = 26;
    localparam int CHILD_MSB    = 25;
    localparam int CHILD_LSB    = 21;
    localparam int INFO_MSB     = 20;
    localparam int INFO_LSB     = 17;
    localparam int TYPE_MSB     = 16;
    localparam int TYPE_LSB     = 14;
    localparam int BUFSEL_BIT   = 13;
    localparam int MSG_MSB      = 12;
    localparam int MSG_LSB      = 0;

    localparam logic [3:0] INFO_UPDATE = 4'h1;
    localparam logic [3:0] INFO_SWAP   = 4'hF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_VB = 3'd2,
        SWAP    = 3'd3,
        HOLD    = 3'd4
    } sched_state_t;

    // A host word whose info field is the swap code is a buffer commit.
    function automatic logic is_commit(input logic [31:0] word);
        return (word[INFO_MSB:INFO_LSB] == INFO_SWAP);
    endfunction

    // Redirect a host update to the given buffer.
    function automatic logic [31:0] set_bufsel(input logic [31:0] word, input logic buf_sel);
        logic [31:0] res;
        res             = word;
        res[BUFSEL_BIT] = buf_sel;
        return res;
    endfunction

    // Broadcast swap command naming the buffer that becomes visible.
    function automatic logic [31:0] swap_word(input logic new_front);
        return {6'b0, 5'b0, INFO_SWAP, 3'b0, new_front, 13'b0};
    endfunction

endpackage

// File: rtl/sync_cmd_fifo.sv
// Single-clock FIFO with show-ahead head output. Push while full and pop
// while empty are ignored; simultaneous push and pop keep the level.
module sync_cmd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      level_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (level_r == (AW+1)'(DEPTH));
    assign empty     = (level_r == (AW+1)'(0));
    assign level     = level_r;
    assign head      = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Storage array write; contents need no reset because level guards reads.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level_r  <= (AW+1)'(0);
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + (AW+1)'(1);
                2'b01:   level_r <= level_r - (AW+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end
endmodule

// File: rtl/sprite_cmd_sched.sv
// Sprite command scheduler: queues host commands and replays them onto the
// shared command bus, redirecting updates to the back buffer and deferring
// each buffer swap to vertical blanking (at most one swap per frame).
// Optional feature macro: SPRITE_SCHED_WAITREQ_EN (stall full-FIFO writes
// with avl_waitrequest instead of dropping and counting them).
module sprite_cmd_sched
    import sprite_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 64,
    parameter int VBLANK_LINE = 480,
    parameter int VTOTAL      = 525
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        avl_chipselect,
    input  logic        avl_write,
    input  logic        avl_read,
    input  logic        avl_address,
    input  logic [31:0] avl_writedata,
    output logic [31:0] avl_readdata,
    output logic        avl_waitrequest,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic [31:0] cmd_out,
    output logic        front_buf,
    output logic        swap_pulse
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    sched_state_t     state_r;
    logic [31:0]      cmd_out_r;
    logic             front_buf_r;
    logic             swap_pulse_r;
    logic             swap_done_r;
    logic [9:0]       vcount_prev_r;
    logic [7:0]       drop_cnt_r;
    logic [31:0]      readdata_r;

    logic             wr_req_s;
    logic             push_s;
    logic             pop_s;
    logic             drop_s;
    logic             waitreq_s;
    logic [31:0]      head_s;
    logic             full_s;
    logic             empty_s;
    logic [LVL_W-1:0] level_s;
    logic             in_vblank_s;
    logic             frame_wrap_s;
    logic             pending_s;
    logic [31:0]      status_s;
    logic             unused_ok_s;

    assign wr_req_s = avl_chipselect & avl_write & (avl_address == 1'b0);

`ifdef SPRITE_SCHED_WAITREQ_EN
    assign waitreq_s = wr_req_s & full_s;
    assign push_s    = wr_req_s & ~full_s;
    assign drop_s    = 1'b0;
`else
    assign waitreq_s = 1'b0;
    assign push_s    = wr_req_s & ~full_s;
    assign drop_s    = wr_req_s & full_s;
`endif

    sync_cmd_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (avl_writedata),
        .head  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .level (level_s)
    );

    assign in_vblank_s  = (vcount >= 10'(VBLANK_LINE)) && (vcount <= 10'(VTOTAL - 1));
    assign frame_wrap_s = (vcount_prev_r == 10'(VTOTAL - 1)) && (vcount == 10'd0);
    assign pending_s    = (state_r == WAIT_VB) || (state_r == SWAP);
    assign status_s     = {front_buf_r, pending_s, 6'b0, drop_cnt_r, 16'(level_s)};
    assign unused_ok_s  = ^hcount;

    // Pop decision: drain updates while issuing, consume the commit on swap.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            ISSUE:   pop_s = ~empty_s & ~is_commit(head_s);
            SWAP:    pop_s = ~empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // Issue FSM with registered bus, swap strobe and buffer tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            cmd_out_r    <= 32'h0;
            swap_pulse_r <= 1'b0;
            front_buf_r  <= 1'b0;
            swap_done_r  <= 1'b0;
        end else begin
            cmd_out_r    <= 32'h0;
            swap_pulse_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!empty_s) state_r <= ISSUE;
                end
                ISSUE: begin
                    if (empty_s) begin
                        state_r <= IDLE;
                    end else if (is_commit(head_s)) begin
                        state_r <= WAIT_VB;
                    end else begin
                        cmd_out_r <= set_bufsel(head_s, ~front_buf_r);
                    end
                end
                WAIT_VB: begin
                    if (in_vblank_s && !swap_done_r) state_r <= SWAP;
                end
                SWAP: begin
                    cmd_out_r    <= swap_word(~front_buf_r);
                    swap_pulse_r <= 1'b1;
                    state_r      <= HOLD;
                end
                HOLD: begin
                    front_buf_r <= ~front_buf_r;
                    swap_done_r <= 1'b1;
                    state_r     <= empty_s ? IDLE : ISSUE;
                end
                default: state_r <= IDLE;
            endcase
            // A new frame re-arms swapping; it overrides a same-cycle set.
            if (frame_wrap_s) swap_done_r <= 1'b0;
        end
    end

    // Previous line register for frame-wrap detection.
    always_ff @(posedge clk) begin
        if (reset) vcount_prev_r <= 10'd0;
        else       vcount_prev_r <= vcount;
    end

    // Saturating count of host writes lost to a full FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_r <= 8'd0;
        end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end
    end

    // Registered status read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_r <= 32'h0;
        end else if (avl_chipselect && avl_read && (avl_address == 1'b1)) begin
            readdata_r <= status_s;
        end else begin
            readdata_r <= 32'h0;
        end
    end

    assign cmd_out         = cmd_out_r;
    assign front_buf       = front_buf_r;
    assign swap_pulse      = swap_pulse_r;
    assign avl_readdata    = readdata_r;
    assign avl_waitrequest = waitreq_s;
endmodule
